// File: rtl/nts_rx_dispatcher.sv
// nts_rx_dispatcher: single-frame receive buffer between the MAC RX stream
// and the NTS engine. Captures one good frame and presents it as a
// first-word-fall-through FIFO. Bad, oversized and busy-time frames are
// dropped and counted.
//
// Ports:
//   i_clk, i_areset          clock, async active-high reset
//   i_mac_rx_data_valid/data MAC word stream (byte-valid field + 64-bit word)
//   i_mac_rx_good/bad_frame  end-of-frame pulses
//   o_packet_available       a complete good frame is held
//   i_packet_read_discard    release the held frame
//   o_data_valid             byte-valid field of the held frame's last word
//   o_fifo_empty/rd_data     FWFT read side, popped with i_fifo_rd_en
//   o_counter_frames/dropped accepted / dropped frame counters
module nts_rx_dispatcher #(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic        i_clk,
  input  logic        i_areset,
  input  logic [7:0]  i_mac_rx_data_valid,
  input  logic [63:0] i_mac_rx_data,
  input  logic        i_mac_rx_good_frame,
  input  logic        i_mac_rx_bad_frame,
  output logic        o_packet_available,
  input  logic        i_packet_read_discard,
  output logic [7:0]  o_data_valid,
  output logic        o_fifo_empty,
  input  logic        i_fifo_rd_en,
  output logic [63:0] o_fifo_rd_data,
  output logic [31:0] o_counter_frames,
  output logic [31:0] o_counter_dropped
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_SYNC,
    ST_IDLE,
    ST_RECEIVE,
    ST_DROP,
    ST_AVAILABLE
  } state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [CW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [7:0]              last_valid_q, last_valid_d;
  logic                    avail_q, avail_d;
  logic                    empty_q, empty_d;
  logic [7:0]              data_valid_q, data_valid_d;
  logic [63:0]             rd_data_q, rd_data_d;
  logic [31:0]             frames_q, frames_d;
  logic [31:0]             dropped_q, dropped_d;
  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [63:0]             mem_q [DEPTH];

  logic word_c;
  logic end_c;
  assign word_c = |i_mac_rx_data_valid;
  assign end_c  = i_mac_rx_good_frame | i_mac_rx_bad_frame;

  // Frame buffer; write-only while capturing, read-only while available.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_addr] <= i_mac_rx_data;
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      state_q      <= ST_SYNC;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      last_valid_q <= '0;
      avail_q      <= 1'b0;
      empty_q      <= 1'b1;
      data_valid_q <= '0;
      rd_data_q    <= '0;
      frames_q     <= '0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      last_valid_q <= last_valid_d;
      avail_q      <= avail_d;
      empty_q      <= empty_d;
      data_valid_q <= data_valid_d;
      rd_data_q    <= rd_data_d;
      frames_q     <= frames_d;
      dropped_q    <= dropped_d;
    end
  end

  // Next-state logic. A word in the same cycle as an end pulse is handled
  // first, then the pulse acts on the resulting state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    last_valid_d = last_valid_q;
    avail_d      = avail_q;
    empty_d      = empty_q;
    data_valid_d = data_valid_q;
    rd_data_d    = rd_data_q;
    frames_d     = frames_q;
    dropped_d    = dropped_q;
    wr_en        = 1'b0;
    wr_addr      = cnt_q[ADDR_WIDTH-1:0];

    case (state_q)
      ST_SYNC: begin
        if (end_c) state_d = ST_IDLE;
      end

      ST_IDLE, ST_RECEIVE: begin
        if (word_c) begin
          if (state_q == ST_RECEIVE && cnt_q == CW'(DEPTH)) begin
            state_d = ST_DROP;
          end else begin
            wr_en        = 1'b1;
            wr_addr      = (state_q == ST_IDLE) ? '0 : cnt_q[ADDR_WIDTH-1:0];
            cnt_d        = (state_q == ST_IDLE) ? CW'(1) : cnt_q + CW'(1);
            last_valid_d = i_mac_rx_data_valid;
            state_d      = ST_RECEIVE;
          end
        end
        if (state_d == ST_DROP) begin
          if (end_c) begin
            state_d   = ST_IDLE;
            dropped_d = dropped_q + 32'd1;
          end
        end else if (state_d == ST_RECEIVE) begin
          if (i_mac_rx_good_frame) begin
            state_d      = ST_AVAILABLE;
            frames_d     = frames_q + 32'd1;
            avail_d      = 1'b1;
            empty_d      = 1'b0;
            data_valid_d = last_valid_d;
            rd_ptr_d     = '0;
            // Prefetch word 0; bypass when it is being written this cycle.
            rd_data_d    = (wr_en && wr_addr == '0) ? i_mac_rx_data : mem_q[0];
          end else if (i_mac_rx_bad_frame) begin
            state_d   = ST_IDLE;
            dropped_d = dropped_q + 32'd1;
          end
        end
      end

      ST_DROP: begin
        if (end_c) begin
          state_d   = ST_IDLE;
          dropped_d = dropped_q + 32'd1;
        end
      end

      ST_AVAILABLE: begin
        if (end_c) dropped_d = dropped_q + 32'd1;
        if (i_packet_read_discard) begin
          state_d      = ST_IDLE;
          cnt_d        = '0;
          avail_d      = 1'b0;
          empty_d      = 1'b1;
          data_valid_d = '0;
        end else if (i_fifo_rd_en && !empty_q) begin
          rd_ptr_d  = rd_ptr_q + CW'(1);
          empty_d   = (rd_ptr_d == cnt_q);
          rd_data_d = mem_q[rd_ptr_d[ADDR_WIDTH-1:0]];
        end
      end

      default: state_d = ST_SYNC;
    endcase
  end

  assign o_packet_available = avail_q;
  assign o_fifo_empty       = empty_q;
  assign o_data_valid       = data_valid_q;
  assign o_fifo_rd_data     = rd_data_q;
  assign o_counter_frames   = frames_q;
  assign o_counter_dropped  = dropped_q;

endmodule
